reg_arbiter2: RTL and testbench
===============================

# reg_arbiter2

Two-requester round-robin arbiter that owns a shared WIDTH-bit register and applies one synchronous operation per grant: hold, load, clear or set. The operations are the same set as the codebase's set/resettable D flip-flop, with clear and set as synchronous commands. The block sits between two masters and a shared state register and serialises their accesses. At most one requester's command reaches the register per clock.

## Interface
- WIDTH, 8, width of shared register and data inputs.
- clk  input  1  single clock; all state changes on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 access request; held high until gnt0 is seen.
- op0  input  2  requester 0 command: 00 hold, 01 load d0, 10 clear, 11 set.
- d0  input  WIDTH  requester 0 load data.
- req1  input  1  requester 1 access request.
- op1  input  2  requester 1 command, same encoding.
- d1  input  WIDTH  requester 1 load data.
- gnt0  output  1  registered one-cycle grant to requester 0.
- gnt1  output  1  registered one-cycle grant to requester 1.
- busy  output  1  high whenever a grant is active (state != IDLE).
- q  output  WIDTH  shared register contents.

## Operation
- State machine: IDLE, GNT0, GNT1 (one-hot or binary, implementer's choice). gnt0 = (state==GNT0), gnt1 = (state==GNT1), busy = gnt0|gnt1. All three are decoded directly from registered state.
- Priority pointer prio (1 bit), 0 = requester 0 preferred.
- IDLE transitions:
  - both req high -> GNT[prio].
  - only reqX high -> GNTX.
  - none -> IDLE.
- GNTx transitions:
  - req of the other requester high -> GNTother.
  - else -> IDLE.
  - reqx is ignored on this edge. The served requester is never re-granted back-to-back; it must wait at least one cycle.
- On each edge leaving GNTx:
  - prio <= other (1-x).
  - q updated from opx, dx sampled in the grant cycle: 00 q unchanged; 01 q <= dx; 10 q <= 0; 11 q <= all ones.
- Requester handshake:
  - Drive req, op, d stable from request until the cycle gnt is high inclusive.
  - Drop req the cycle after gnt, or keep it high to queue another access. A kept-high req is treated as a new request from IDLE.
- Op/data of a requester without grant never affect q.
- Async reset (reset_n low, any time including mid-grant): state IDLE, prio 0, q 0, gnt0/gnt1/busy 0 immediately. The in-flight command is discarded.
- Release of reset is synchronous to clk. The first evaluation occurs on the first rising edge with reset_n high.

## Timing
- Request to grant: req sampled at edge E; gnt high in cycle after E (1-cycle latency from IDLE).
- Grant to data: q reflects the command at the edge ending the grant cycle (2 edges after req sampled).
- Throughput:
  - Alternating continuous requests: one grant per cycle, alternating 0/1, no idle cycles.
  - Single continuous requester: one grant every 2 cycles (GNTx, IDLE, GNTx, ...).
- Simultaneous first requests after reset: requester 0 wins; requester 1 granted the next cycle.
- Outputs are glitch-free registered decodes. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert reset_n=0 mid-GNT1 with op1=01, d1=8'hA5 -> gnt1, busy, q drop to 0 immediately; q stays 8'h00 after release; next grant from IDLE.
- Single requester: req0 high continuously, op0=01, d0=8'h3C -> gnt0 pattern 1,0,1,0; q=8'h3C after first grant edge; no gnt1.
- Contention: after reset, req0 and req1 asserted together, op0=11, op1=10 -> gnt0 in cycle 1, gnt1 in cycle 2; q=8'hFF after cycle 1, 8'h00 after cycle 2.
- Fairness: both reqs held high 8 cycles -> gnt alternates 0,1,0,1,...; never two consecutive grants to the same requester.
- Hold and non-granted isolation: q=8'h5A, req1 granted with op1=00 while op0=10 and req0 low -> q remains 8'h5A; busy high only during the gnt1 cycle.
- Pointer: req1 alone served, then req0 and req1 together from IDLE -> gnt0 first (prio moved to 0).

Source files
------------

// File: rtl/reg_arbiter2_if.sv
// Bundle between the two requesting masters and the shared-register arbiter.
// Both requesters sit on the master side; the arbiter is the slave.
interface reg_arbiter2_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [1:0]       op0;
  logic [WIDTH-1:0] d0;
  logic             req1;
  logic [1:0]       op1;
  logic [WIDTH-1:0] d1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic [WIDTH-1:0] q;

  modport master (
    output req0, op0, d0, req1, op1, d1,
    input  gnt0, gnt1, busy, q
  );

  modport slave (
    input  req0, op0, d0, req1, op1, d1,
    output gnt0, gnt1, busy, q
  );
endinterface

// File: rtl/reg_arbiter2.sv
// Round-robin arbiter for two masters sharing one WIDTH-bit register.
// Each grant applies exactly one hold/load/clear/set command to the register.
//
// state | meaning
// IDLE  | no grant; next request (or prio on a tie) picks the winner
// GNT0  | requester 0 owns the register this cycle; op0/d0 applied on exit
// GNT1  | requester 1 owns the register this cycle; op1/d1 applied on exit
module reg_arbiter2 #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          reset_n,
  reg_arbiter2_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  state_t           state;
  state_t           state_nxt;
  logic             prio;
  logic [WIDTH-1:0] q_r;
  logic             gnt0_r;
  logic             gnt1_r;
  logic             busy_r;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [1:0]       op,
    input logic [WIDTH-1:0] d,
    input logic [WIDTH-1:0] cur
  );
    logic [WIDTH-1:0] res;
    case (op)
      OP_HOLD:  res = cur;
      OP_LOAD:  res = d;
      OP_CLEAR: res = '0;
      default:  res = '1;
    endcase
    return res;
  endfunction

  // The owner's own request is ignored while granted, so it can never be
  // re-granted on the following edge.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) state_nxt = prio ? GNT1 : GNT0;
        else if (bus.req0)        state_nxt = GNT0;
        else if (bus.req1)        state_nxt = GNT1;
        else                      state_nxt = IDLE;
      end
      GNT0:    state_nxt = bus.req1 ? GNT1 : IDLE;
      GNT1:    state_nxt = bus.req0 ? GNT0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant outputs are registered copies of the next-state decode, so they
  // always equal the decode of the current state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      prio   <= 1'b0;
      q_r    <= '0;
      gnt0_r <= 1'b0;
      gnt1_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt0_r <= (state_nxt == GNT0);
      gnt1_r <= (state_nxt == GNT1);
      busy_r <= (state_nxt != IDLE);
      case (state)
        GNT0: begin
          prio <= 1'b1;
          q_r  <= apply_op(bus.op0, bus.d0, q_r);
        end
        GNT1: begin
          prio <= 1'b0;
          q_r  <= apply_op(bus.op1, bus.d1, q_r);
        end
        default: begin
          prio <= prio;
          q_r  <= q_r;
        end
      endcase
    end
  end

  assign bus.gnt0 = gnt0_r;
  assign bus.gnt1 = gnt1_r;
  assign bus.busy = busy_r;
  assign bus.q    = q_r;

  a_one_grant : assert property (
    @(posedge clk) disable iff (!reset_n) !(bus.gnt0 && bus.gnt1)
  );

  a_no_regrant0 : assert property (
    @(posedge clk) disable iff (!reset_n) bus.gnt0 |=> !bus.gnt0
  );

  a_no_regrant1 : assert property (
    @(posedge clk) disable iff (!reset_n) bus.gnt1 |=> !bus.gnt1
  );

endmodule

// File: tb/tb_reg_arbiter2.sv
// Scoreboard bench for reg_arbiter2: inputs driven at the falling edge,
// expected outputs queued and checked at the following falling edge.
module tb_reg_arbiter2;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  typedef struct packed {
    logic       r0;
    logic [1:0] o0;
    logic [7:0] dd0;
    logic       r1;
    logic [1:0] o1;
    logic [7:0] dd1;
    logic       eg0;
    logic       eg1;
    logic [7:0] eq;
  } stim_t;

  typedef struct packed {
    logic       g0;
    logic       g1;
    logic       b;
    logic [7:0] q;
  } exp_t;

  exp_t sb[$];

  reg_arbiter2_if #(.WIDTH(8)) bus ();

  reg_arbiter2 #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t mk_stim(
    input logic r0, input logic [1:0] o0, input logic [7:0] dd0,
    input logic r1, input logic [1:0] o1, input logic [7:0] dd1,
    input logic eg0, input logic eg1, input logic [7:0] eq
  );
    stim_t s;
    s.r0 = r0; s.o0 = o0; s.dd0 = dd0;
    s.r1 = r1; s.o1 = o1; s.dd1 = dd1;
    s.eg0 = eg0; s.eg1 = eg1; s.eq = eq;
    return s;
  endfunction

  function automatic exp_t mk_exp(input logic g0, input logic g1, input logic [7:0] q);
    exp_t e;
    e.g0 = g0; e.g1 = g1; e.b = g0 | g1; e.q = q;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    bus.req0 = s.r0; bus.op0 = s.o0; bus.d0 = s.dd0;
    bus.req1 = s.r1; bus.op1 = s.o1; bus.d1 = s.dd1;
  endtask

  task automatic test_reset;
    exp_t e;
    @(negedge clk);
    total++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== 11'h000) begin
      bad++;
      $display("FAIL reset_hold: got g0/g1/busy/q=%b%b%b/%h expected 000/00",
               bus.gnt0, bus.gnt1, bus.busy, bus.q);
    end
    reset_n = 1'b1;
    sb.push_back(mk_exp(1'b0, 1'b0, 8'h00));
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== e) begin
      bad++;
      $display("FAIL reset_release: got g0/g1/busy/q=%b%b%b/%h expected %b%b%b/%h",
               bus.gnt0, bus.gnt1, bus.busy, bus.q, e.g0, e.g1, e.b, e.q);
    end
  endtask

  task automatic test_contention;
    stim_t tbl [3];
    exp_t  e;
    tbl[0] = mk_stim(1, 2'b11, 8'h00, 1, 2'b10, 8'h00, 1, 0, 8'h00);
    tbl[1] = mk_stim(0, 2'b11, 8'h00, 1, 2'b10, 8'h00, 0, 1, 8'hFF);
    tbl[2] = mk_stim(0, 2'b11, 8'h00, 0, 2'b10, 8'h00, 0, 0, 8'h00);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(mk_exp(tbl[i].eg0, tbl[i].eg1, tbl[i].eq));
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== e) begin
        bad++;
        $display("FAIL contention step %0d: got g0/g1/busy/q=%b%b%b/%h expected %b%b%b/%h",
                 i, bus.gnt0, bus.gnt1, bus.busy, bus.q, e.g0, e.g1, e.b, e.q);
      end
    end
  endtask

  task automatic test_fairness;
    stim_t tbl [9];
    exp_t  e;
    for (int i = 0; i < 9; i++)
      tbl[i] = mk_stim(i < 8, 2'b00, 8'hAA, i < 8, 2'b00, 8'h55,
                       (i < 8) && (i % 2 == 0), (i < 8) && (i % 2 == 1), 8'h00);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(mk_exp(tbl[i].eg0, tbl[i].eg1, tbl[i].eq));
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== e) begin
        bad++;
        $display("FAIL fairness step %0d: got g0/g1/busy/q=%b%b%b/%h expected %b%b%b/%h",
                 i, bus.gnt0, bus.gnt1, bus.busy, bus.q, e.g0, e.g1, e.b, e.q);
      end
    end
  endtask

  task automatic test_single;
    stim_t tbl [5];
    exp_t  e;
    tbl[0] = mk_stim(1, 2'b01, 8'h3C, 0, 2'b11, 8'hEE, 1, 0, 8'h00);
    tbl[1] = mk_stim(1, 2'b01, 8'h3C, 0, 2'b11, 8'hEE, 0, 0, 8'h3C);
    tbl[2] = mk_stim(1, 2'b01, 8'h3C, 0, 2'b11, 8'hEE, 1, 0, 8'h3C);
    tbl[3] = mk_stim(1, 2'b01, 8'h3C, 0, 2'b11, 8'hEE, 0, 0, 8'h3C);
    tbl[4] = mk_stim(0, 2'b01, 8'h3C, 0, 2'b11, 8'hEE, 0, 0, 8'h3C);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(mk_exp(tbl[i].eg0, tbl[i].eg1, tbl[i].eq));
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== e) begin
        bad++;
        $display("FAIL single step %0d: got g0/g1/busy/q=%b%b%b/%h expected %b%b%b/%h",
                 i, bus.gnt0, bus.gnt1, bus.busy, bus.q, e.g0, e.g1, e.b, e.q);
      end
    end
  endtask

  task automatic test_hold_isolation;
    stim_t tbl [5];
    exp_t  e;
    tbl[0] = mk_stim(1, 2'b01, 8'h5A, 0, 2'b11, 8'hFF, 1, 0, 8'h3C);
    tbl[1] = mk_stim(0, 2'b01, 8'h5A, 0, 2'b11, 8'hFF, 0, 0, 8'h5A);
    tbl[2] = mk_stim(0, 2'b10, 8'h00, 1, 2'b00, 8'hFF, 0, 1, 8'h5A);
    tbl[3] = mk_stim(0, 2'b10, 8'h00, 0, 2'b00, 8'hFF, 0, 0, 8'h5A);
    tbl[4] = mk_stim(0, 2'b10, 8'h00, 0, 2'b01, 8'h11, 0, 0, 8'h5A);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(mk_exp(tbl[i].eg0, tbl[i].eg1, tbl[i].eq));
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== e) begin
        bad++;
        $display("FAIL hold_isolation step %0d: got g0/g1/busy/q=%b%b%b/%h expected %b%b%b/%h",
                 i, bus.gnt0, bus.gnt1, bus.busy, bus.q, e.g0, e.g1, e.b, e.q);
      end
    end
  endtask

  task automatic test_pointer;
    stim_t tbl [10];
    exp_t  e;
    tbl[0] = mk_stim(0, 2'b00, 8'h00, 1, 2'b11, 8'h00, 0, 1, 8'h5A);
    tbl[1] = mk_stim(0, 2'b00, 8'h00, 0, 2'b11, 8'h00, 0, 0, 8'hFF);
    tbl[2] = mk_stim(1, 2'b10, 8'h00, 1, 2'b01, 8'h77, 1, 0, 8'hFF);
    tbl[3] = mk_stim(0, 2'b10, 8'h00, 1, 2'b01, 8'h77, 0, 1, 8'h00);
    tbl[4] = mk_stim(0, 2'b10, 8'h00, 0, 2'b01, 8'h77, 0, 0, 8'h77);
    tbl[5] = mk_stim(1, 2'b00, 8'h99, 0, 2'b01, 8'h77, 1, 0, 8'h77);
    tbl[6] = mk_stim(0, 2'b00, 8'h99, 0, 2'b01, 8'h77, 0, 0, 8'h77);
    tbl[7] = mk_stim(1, 2'b11, 8'h00, 1, 2'b10, 8'h00, 0, 1, 8'h77);
    tbl[8] = mk_stim(1, 2'b11, 8'h00, 0, 2'b10, 8'h00, 1, 0, 8'h00);
    tbl[9] = mk_stim(0, 2'b11, 8'h00, 0, 2'b10, 8'h00, 0, 0, 8'hFF);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(mk_exp(tbl[i].eg0, tbl[i].eg1, tbl[i].eq));
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== e) begin
        bad++;
        $display("FAIL pointer step %0d: got g0/g1/busy/q=%b%b%b/%h expected %b%b%b/%h",
                 i, bus.gnt0, bus.gnt1, bus.busy, bus.q, e.g0, e.g1, e.b, e.q);
      end
    end
  endtask

  task automatic test_midgrant_reset;
    stim_t tbl [3];
    exp_t  e;
    drive(mk_stim(0, 2'b00, 8'h00, 1, 2'b01, 8'hA5, 0, 1, 8'hFF));
    sb.push_back(mk_exp(1'b0, 1'b1, 8'hFF));
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== e) begin
      bad++;
      $display("FAIL midreset_grant: got g0/g1/busy/q=%b%b%b/%h expected %b%b%b/%h",
               bus.gnt0, bus.gnt1, bus.busy, bus.q, e.g0, e.g1, e.b, e.q);
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== 11'h000) begin
      bad++;
      $display("FAIL midreset_immediate: got g0/g1/busy/q=%b%b%b/%h expected 000/00",
               bus.gnt0, bus.gnt1, bus.busy, bus.q);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== 11'h000) begin
      bad++;
      $display("FAIL midreset_held: got g0/g1/busy/q=%b%b%b/%h expected 000/00",
               bus.gnt0, bus.gnt1, bus.busy, bus.q);
    end
    drive(mk_stim(0, 2'b00, 8'h00, 0, 2'b01, 8'hA5, 0, 0, 8'h00));
    reset_n = 1'b1;
    sb.push_back(mk_exp(1'b0, 1'b0, 8'h00));
    @(posedge clk); @(negedge clk);
    e = sb.pop_front();
    total++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== e) begin
      bad++;
      $display("FAIL midreset_release: got g0/g1/busy/q=%b%b%b/%h expected %b%b%b/%h",
               bus.gnt0, bus.gnt1, bus.busy, bus.q, e.g0, e.g1, e.b, e.q);
    end
    tbl[0] = mk_stim(1, 2'b01, 8'hC3, 1, 2'b00, 8'h00, 1, 0, 8'h00);
    tbl[1] = mk_stim(0, 2'b01, 8'hC3, 1, 2'b00, 8'h00, 0, 1, 8'hC3);
    tbl[2] = mk_stim(0, 2'b01, 8'hC3, 0, 2'b00, 8'h00, 0, 0, 8'hC3);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sb.push_back(mk_exp(tbl[i].eg0, tbl[i].eg1, tbl[i].eq));
      @(posedge clk); @(negedge clk);
      e = sb.pop_front();
      total++;
      if ({bus.gnt0, bus.gnt1, bus.busy, bus.q} !== e) begin
        bad++;
        $display("FAIL midreset_regrant step %0d: got g0/g1/busy/q=%b%b%b/%h expected %b%b%b/%h",
                 i, bus.gnt0, bus.gnt1, bus.busy, bus.q, e.g0, e.g1, e.b, e.q);
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    drive(mk_stim(0, 2'b00, 8'h00, 0, 2'b00, 8'h00, 0, 0, 8'h00));
    test_reset;
    test_contention;
    test_fairness;
    test_single;
    test_hold_isolation;
    test_pointer;
    test_midgrant_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
